// File: rtl/sirv_gnrl_regbank_arb_if.sv
// Write-request, bank-hold and read-port signals shared by the regbank arbiter and its requesters.
interface sirv_gnrl_regbank_arb_if #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int AW   = 3
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req_vld;
  logic [NREQ-1:0]    req_rdy;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               bank_hold;
  logic               wr_pend;
  logic [IDW-1:0]     wr_id;
  logic               wr_en;
  logic [AW-1:0]      rd_addr;
  logic [DW-1:0]      rd_data;

  modport master (
    output req_vld, req_addr, req_data, bank_hold, rd_addr,
    input  req_rdy, wr_pend, wr_id, wr_en, rd_data
  );

  modport slave (
    input  req_vld, req_addr, req_data, bank_hold, rd_addr,
    output req_rdy, wr_pend, wr_id, wr_en, rd_data
  );
endinterface

// File: rtl/sirv_gnrl_regbank_arb.sv
// Round-robin write arbiter: one grant per cycle into a single staging entry, committed to an
// owned no-reset register bank one cycle later; a commit and a new accept can share a cycle.
module sirv_gnrl_regbank_arb #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int AW   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  sirv_gnrl_regbank_arb_if.slave bus
);
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic {EMPTY, FULL} stg_st_e;

  stg_st_e         stg_st_q, stg_st_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  stg_id_q, stg_id_d;
  logic [AW-1:0]   stg_addr_q, stg_addr_d;
  logic [DW-1:0]   stg_data_q, stg_data_d;
  logic [DW-1:0]   bank_q [DEPTH];
  logic [DEPTH-1:0] bank_le;

  logic            win_vld;
  logic [IDW-1:0]  win_id;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic [IDW:0]    cand;
  logic            stg_vld, commit, acc;

  assign stg_vld = (stg_st_q == FULL);
  assign commit  = stg_vld && !bus.bank_hold && !rst;
  assign acc     = win_vld && (!stg_vld || commit) && !rst;

  // Scan from rr_ptr upward with wrap; the first valid requester wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!win_vld && bus.req_vld[cand[IDW-1:0]]) begin
        win_vld = 1'b1;
        win_id  = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    win_addr    = '0;
    win_data    = '0;
    bus.req_rdy = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == IDW'(i)) begin
        win_addr       = bus.req_addr[i*AW +: AW];
        win_data       = bus.req_data[i*DW +: DW];
        bus.req_rdy[i] = acc;
      end
    end
  end

  always_comb begin
    stg_st_d   = stg_st_q;
    rr_ptr_d   = rr_ptr_q;
    stg_id_d   = stg_id_q;
    stg_addr_d = stg_addr_q;
    stg_data_d = stg_data_q;
    if (acc) begin
      stg_st_d   = FULL;
      rr_ptr_d   = (win_id == IDW'(NREQ-1)) ? '0 : win_id + IDW'(1);
      stg_id_d   = win_id;
      stg_addr_d = win_addr;
      stg_data_d = win_data;
    end else if (commit) begin
      stg_st_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_st_q <= EMPTY;
      rr_ptr_q <= '0;
      stg_id_q <= '0;
    end else begin
      stg_st_q <= stg_st_d;
      rr_ptr_q <= rr_ptr_d;
      stg_id_q <= stg_id_d;
    end
  end

  // Staging payload is meaningless while EMPTY, so it carries no reset.
  always_ff @(posedge clk) begin
    stg_addr_q <= stg_addr_d;
    stg_data_q <= stg_data_d;
  end

  always_comb begin
    bank_le = '0;
    for (int e = 0; e < DEPTH; e++) begin
      bank_le[e] = commit && (stg_addr_q == AW'(e));
    end
  end

  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (bank_le[e]) bank_q[e] <= stg_data_q;
    end
  end

  assign bus.wr_pend = stg_vld;
  assign bus.wr_en   = commit;
  assign bus.wr_id   = stg_id_q;
  assign bus.rd_data = bank_q[bus.rd_addr];
endmodule

// File: tb/tb_sirv_gnrl_regbank_arb.sv
// Directed bench for sirv_gnrl_regbank_arb: inputs change 1ns after the rising edge and
// outputs are sampled mid-cycle against hand-computed values.
module tb_sirv_gnrl_regbank_arb;
  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int AW   = 3;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sirv_gnrl_regbank_arb_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

  sirv_gnrl_regbank_arb #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #3;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_vld[i]            = v;
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_data[i*DW +: DW]  = d;
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    bus.rd_addr = a;
    #1;
    chk(tag, bus.rd_data, exp);
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_vld   = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.bank_hold = 1'b0;
    bus.rd_addr   = '0;
    tick();

    // Reset blocks handshakes even with requests pending.
    bus.req_vld = 4'hF;
    mid();
    chk("rst_rdy", bus.req_rdy, 4'h0);
    chk("rst_wr_en", bus.wr_en, 1'b0);
    tick();
    bus.req_vld = '0;
    rst = 1'b0;
    mid();
    chk("rst_rr_ptr", dut.rr_ptr_q, 2'd0);
    chk("rst_wr_pend", bus.wr_pend, 1'b0);
    chk("rst_wr_id", bus.wr_id, 2'd0);
    chk("rst_wr_en_after", bus.wr_en, 1'b0);
    tick();

    // Single write from requester 2.
    set_req(2, 1'b1, 3'd5, 32'hDEADBEEF);
    mid();
    chk("single_rdy", bus.req_rdy, 4'b0100);
    tick();
    bus.req_vld = '0;
    mid();
    chk("single_wr_en", bus.wr_en, 1'b1);
    chk("single_wr_id", bus.wr_id, 2'd2);
    chk("single_wr_pend", bus.wr_pend, 1'b1);
    chk("single_rr_ptr", dut.rr_ptr_q, 2'd3);
    tick();
    chk("single_wr_en_done", bus.wr_en, 1'b0);
    chk("single_pend_done", bus.wr_pend, 1'b0);
    rd_chk("single_rd", 3'd5, 32'hDEADBEEF);

    // Reset pulse to bring rr_ptr back to 0; bank must survive it.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_chk("bank_persist", 3'd5, 32'hDEADBEEF);

    // All four valid continuously: strict rotation, one commit per cycle.
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i), 32'h100 + i);
    for (int c = 0; c < 8; c++) begin
      mid();
      chk($sformatf("rr_grant%0d", c), bus.req_rdy, 64'd1 << (c % 4));
      chk($sformatf("rr_wr_en%0d", c), bus.wr_en, (c >= 1) ? 1'b1 : 1'b0);
      tick();
    end
    bus.req_vld = '0;
    mid();
    chk("rr_last_commit", bus.wr_en, 1'b1);
    chk("rr_last_id", bus.wr_id, 2'd3);
    tick();
    rd_chk("rr_bank3", 3'd3, 32'h103);

    // Move rr_ptr to 2 via a single grant to requester 1.
    set_req(1, 1'b1, 3'd7, 32'h77);
    tick();
    bus.req_vld = '0;
    tick();
    chk("race_rr_ptr", dut.rr_ptr_q, 2'd2);

    // Same-address race: 3 wins first, 1 overwrites.
    set_req(1, 1'b1, 3'd0, 32'h11);
    set_req(3, 1'b1, 3'd0, 32'h33);
    mid();
    chk("race_first", bus.req_rdy, 4'b1000);
    tick();
    bus.req_vld[3] = 1'b0;
    mid();
    chk("race_second", bus.req_rdy, 4'b0010);
    chk("race_id3", bus.wr_id, 2'd3);
    tick();
    bus.req_vld[1] = 1'b0;
    mid();
    chk("race_id1", bus.wr_id, 2'd1);
    chk("race_wr_en", bus.wr_en, 1'b1);
    tick();
    rd_chk("race_bank0", 3'd0, 32'h11);

    // bank_hold stall: one accept, then frozen for the rest of the hold.
    bus.bank_hold = 1'b1;
    set_req(0, 1'b1, 3'd2, 32'hA0);
    set_req(1, 1'b1, 3'd3, 32'hB1);
    mid();
    chk("hold_accept", bus.req_rdy, 4'b0001);
    tick();
    bus.req_vld[0] = 1'b0;
    for (int h = 1; h < 3; h++) begin
      mid();
      chk($sformatf("hold_rdy%0d", h), bus.req_rdy, 4'b0000);
      chk($sformatf("hold_pend%0d", h), bus.wr_pend, 1'b1);
      chk($sformatf("hold_wr_en%0d", h), bus.wr_en, 1'b0);
      tick();
    end
    bus.bank_hold = 1'b0;
    mid();
    chk("release_wr_en", bus.wr_en, 1'b1);
    chk("release_rdy", bus.req_rdy, 4'b0010);
    chk("release_id", bus.wr_id, 2'd0);
    tick();
    bus.req_vld = '0;
    mid();
    chk("release_id1", bus.wr_id, 2'd1);
    tick();
    rd_chk("hold_bank2", 3'd2, 32'hA0);
    rd_chk("hold_bank3", 3'd3, 32'hB1);

    // Reset mid-operation: staged write to addr 4 is dropped.
    set_req(2, 1'b1, 3'd4, 32'h44);
    tick();
    bus.req_vld = '0;
    tick();
    bus.bank_hold = 1'b1;
    set_req(0, 1'b1, 3'd4, 32'hAA);
    mid();
    chk("rstmid_accept", bus.req_rdy, 4'b0001);
    tick();
    bus.req_vld[0] = 1'b0;
    mid();
    chk("rstmid_pend", bus.wr_pend, 1'b1);
    tick();
    rst = 1'b1;
    bus.bank_hold = 1'b0;
    bus.req_vld[1] = 1'b1;
    mid();
    chk("rstmid_rdy", bus.req_rdy, 4'b0000);
    chk("rstmid_wr_en", bus.wr_en, 1'b0);
    tick();
    rst = 1'b0;
    bus.req_vld = '0;
    mid();
    chk("rstmid_pend_clr", bus.wr_pend, 1'b0);
    chk("rstmid_rr_ptr", dut.rr_ptr_q, 2'd0);
    chk("rstmid_no_wr", bus.wr_en, 1'b0);
    rd_chk("rstmid_bank4", 3'd4, 32'h44);
    tick();

    // Withdrawal: requester 0 gives up while blocked; requester 1 is served.
    bus.bank_hold = 1'b1;
    set_req(2, 1'b1, 3'd6, 32'h66);
    mid();
    chk("wd_stage", bus.req_rdy, 4'b0100);
    tick();
    bus.req_vld[2] = 1'b0;
    set_req(0, 1'b1, 3'd1, 32'hBAD0);
    mid();
    chk("wd_blocked", bus.req_rdy, 4'b0000);
    tick();
    bus.req_vld[0] = 1'b0;
    set_req(1, 1'b1, 3'd1, 32'h1111);
    tick();
    bus.bank_hold = 1'b0;
    mid();
    chk("wd_grant1", bus.req_rdy, 4'b0010);
    chk("wd_commit_id", bus.wr_id, 2'd2);
    tick();
    bus.req_vld = '0;
    mid();
    chk("wd_id1", bus.wr_id, 2'd1);
    chk("wd_wr_en", bus.wr_en, 1'b1);
    tick();
    rd_chk("wd_bank1", 3'd1, 32'h1111);
    rd_chk("wd_bank6", 3'd6, 32'h66);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
